ce_set_gen: RTL and testbench

Clock-enable and synchronous-set strobe generator that drives the CE and S pins of a bank of D flip-flops with sync set and clock enable. It produces a periodic one-cycle CE pulse at a programmable division of the clock. On a four-phase request handshake it issues a fixed-length S pulse that forces the downstream bank to ones. All outputs are registered, so they connect straight to CE/S with no glue logic.

---
 rtl/ce_set_gen_pkg.sv | 16 +
 rtl/ce_div_cnt.sv | 69 ++++++
 rtl/ce_set_gen.sv | 86 ++++++++
 tb/tb_ce_set_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ce_set_gen_pkg.sv
// Shared constants for the CE / sync-set strobe generator.
// State encodings, the set-length counter width and the divisor clamp.
package ce_set_gen_pkg;

  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_SET = 2'd1;
  localparam logic [1:0] ST_ACK = 2'd2;

  // Wide enough for the largest legal set length (255).
  localparam int SCNT_W = $clog2(255 + 1);

  function automatic logic [31:0] div_clamp(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/ce_div_cnt.sv
// Programmable divider producing the next-cycle CE value.
// Holds the active and pending divisors; pending values apply at a wrap or while idle.
module ce_div_cnt
  import ce_set_gen_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int INIT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             hold,
  input  logic [WIDTH-1:0] div,
  input  logic             div_ld,
  output logic             ce_nxt
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(div_clamp(32'(INIT_DIV)));

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_p;
  logic [WIDTH-1:0] cnt;
  logic             pend;
  logic [WIDTH-1:0] div_in;
  logic             wrap;
  logic             run;
  logic             apply_now;

  assign div_in = WIDTH'(div_clamp(32'(div)));

  // ">=" rather than "==" so a shrunken divisor wraps on the next enabled edge.
  assign wrap      = en && (cnt >= (div_q - WIDTH'(1)));
  assign run       = !clear && !hold;
  assign apply_now = run && (wrap || !en);
  assign ce_nxt    = run && wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= RST_DIV;
      div_p <= RST_DIV;
      pend  <= 1'b0;
    end else begin
      if (clear) begin
        cnt <= '0;
      end else if (run) begin
        if (wrap)
          cnt <= '0;
        else if (en)
          cnt <= cnt + WIDTH'(1);
      end

      if (div_ld) begin
        if (apply_now) begin
          div_q <= div_in;
          pend  <= 1'b0;
        end else begin
          div_p <= div_in;
          pend  <= 1'b1;
        end
      end else if (pend && apply_now) begin
        div_q <= div_p;
        pend  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ce_set_gen.sv
// Clock-enable and synchronous-set strobe generator for a downstream DFF bank.
// Four-phase SREQ/SACK handshake produces a fixed-length S pulse; CE and S never overlap.
module ce_set_gen
  import ce_set_gen_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int INIT_DIV = 1,
  parameter int SET_LEN  = 1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             DIV_LD,
  input  logic             SREQ,
  output logic             SACK,
  output logic             CE,
  output logic             S
);

  logic [1:0]        state;
  logic [SCNT_W-1:0] scnt;
  logic              in_run;
  logic              clear;
  logic              ce_nxt;

  assign in_run = (state == ST_RUN);
  assign clear  = in_run && SREQ;

  ce_div_cnt #(
    .WIDTH    (WIDTH),
    .INIT_DIV (INIT_DIV)
  ) u_div (
    .clk    (C),
    .rst    (CLR),
    .en     (EN),
    .clear  (clear),
    .hold   (!in_run),
    .div    (DIV),
    .div_ld (DIV_LD),
    .ce_nxt (ce_nxt)
  );

  // ce_nxt is already suppressed outside RUN and on the SREQ edge, so CE needs no gating here.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= ST_RUN;
      scnt  <= '0;
      S     <= 1'b0;
      SACK  <= 1'b0;
      CE    <= 1'b0;
    end else begin
      CE <= ce_nxt;
      case (state)
        ST_RUN: begin
          if (SREQ) begin
            state <= ST_SET;
            S     <= 1'b1;
            scnt  <= SCNT_W'(SET_LEN - 1);
          end
        end
        ST_SET: begin
          if (scnt == '0) begin
            S     <= 1'b0;
            SACK  <= 1'b1;
            state <= ST_ACK;
          end else begin
            scnt <= scnt - SCNT_W'(1);
          end
        end
        ST_ACK: begin
          if (!SREQ) begin
            SACK  <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
          S     <= 1'b0;
          SACK  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ce_set_gen.sv
// Directed self-checking bench for ce_set_gen with hand-computed CE/S/SACK sequences.
// A second instance with SET_LEN=2 shares all inputs except its own set request.
module tb_ce_set_gen;

  logic       C;
  logic       CLR;
  logic       EN;
  logic [7:0] DIV;
  logic       DIV_LD;
  logic       SREQ;
  logic       SACK;
  logic       CE;
  logic       S;
  logic       sreq2;
  logic       sack2;
  logic       ce2;
  logic       s2;

  int vectors;
  int miscompares;

  ce_set_gen #(.WIDTH(8), .INIT_DIV(3), .SET_LEN(3)) u_dut (
    .C(C), .CLR(CLR), .EN(EN), .DIV(DIV), .DIV_LD(DIV_LD),
    .SREQ(SREQ), .SACK(SACK), .CE(CE), .S(S)
  );

  ce_set_gen #(.WIDTH(8), .INIT_DIV(3), .SET_LEN(2)) u_dut2 (
    .C(C), .CLR(CLR), .EN(EN), .DIV(DIV), .DIV_LD(DIV_LD),
    .SREQ(sreq2), .SACK(sack2), .CE(ce2), .S(s2)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic check_output(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Raise CLR between edges and confirm every output drops before the next edge.
  task automatic pulse_clr(input string tag);
    #2;
    CLR = 1'b1;
    #1;
    check_output({tag, "_ce"},   CE,    1'b0);
    check_output({tag, "_s"},    S,     1'b0);
    check_output({tag, "_sack"}, SACK,  1'b0);
    check_output({tag, "_ce2"},  ce2,   1'b0);
    check_output({tag, "_s2"},   s2,    1'b0);
    check_output({tag, "_sack2"}, sack2, 1'b0);
    #1;
    CLR = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    CLR    = 1'b1;
    EN     = 1'b0;
    DIV    = 8'd0;
    DIV_LD = 1'b0;
    SREQ   = 1'b0;
    sreq2  = 1'b0;
    tick();
    tick();
    check_output("rst_ce",   CE,    1'b0);
    check_output("rst_s",    S,     1'b0);
    check_output("rst_sack", SACK,  1'b0);
    check_output("rst_ce2",  ce2,   1'b0);
    check_output("rst_s2",   s2,    1'b0);
    check_output("rst_sack2", sack2, 1'b0);

    // Reset release with div 3: CE after edges 3, 6, 9.
    CLR = 1'b0;
    EN  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_output("a_ce", CE, (i % 3) == 2);
    end

    // Load 4 at cnt=1: old wrap still fires, then period 4.
    tick();
    check_output("b_cnt1", CE, 1'b0);
    DIV    = 8'd4;
    DIV_LD = 1'b1;
    tick();
    check_output("b_ld", CE, 1'b0);
    DIV_LD = 1'b0;
    tick();
    check_output("b_old_wrap", CE, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("b_div4", CE, (i % 4) == 3);
    end

    // DIV=0 clamps to 1 after the pending wrap: CE continuously high.
    DIV    = 8'd0;
    DIV_LD = 1'b1;
    tick();
    check_output("b0_ld", CE, 1'b0);
    DIV_LD = 1'b0;
    tick();
    check_output("b0_w1", CE, 1'b0);
    tick();
    check_output("b0_w2", CE, 1'b0);
    tick();
    check_output("b0_wrap", CE, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("b0_every", CE, 1'b1);
    end

    // Back to 3; a load on a wrap edge applies at once.
    DIV    = 8'd3;
    DIV_LD = 1'b1;
    tick();
    check_output("b3_wrap", CE, 1'b1);
    DIV_LD = 1'b0;
    tick();
    check_output("b3_c1", CE, 1'b0);
    tick();
    check_output("b3_c2", CE, 1'b0);
    tick();
    check_output("b3_ce", CE, 1'b1);

    // Held handshake with SET_LEN=3.
    SREQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("c_s",    S,    1'b1);
      check_output("c_ce",   CE,   1'b0);
      check_output("c_sack", SACK, 1'b0);
    end
    tick();
    check_output("c_s_fall",  S,    1'b0);
    check_output("c_sack_up", SACK, 1'b1);
    check_output("c_ack_ce",  CE,   1'b0);
    tick();
    check_output("c_sack_hold", SACK, 1'b1);
    check_output("c_ack_ce2",   CE,   1'b0);
    SREQ = 1'b0;
    tick();
    check_output("c_sack_fall", SACK, 1'b0);
    check_output("c_run_ce",    CE,   1'b0);
    tick();
    check_output("c_r1", CE, 1'b0);
    tick();
    check_output("c_r2", CE, 1'b0);
    tick();
    check_output("c_r3", CE, 1'b1);

    // SREQ on the wrap edge wins; one-cycle request still gets a full S.
    tick();
    check_output("d_c1", CE, 1'b0);
    tick();
    check_output("d_c2", CE, 1'b0);
    SREQ = 1'b1;
    tick();
    check_output("d_s_wins", S,  1'b1);
    check_output("d_no_ce",  CE, 1'b0);
    SREQ = 1'b0;
    tick();
    check_output("d_s2", S, 1'b1);
    tick();
    check_output("d_s3", S, 1'b1);
    tick();
    check_output("d_s_fall",  S,    1'b0);
    check_output("d_sack_up", SACK, 1'b1);
    tick();
    check_output("d_sack_fall", SACK, 1'b0);
    tick();
    check_output("d_r1", CE, 1'b0);
    tick();
    check_output("d_r2", CE, 1'b0);
    tick();
    check_output("d_r3", CE, 1'b1);

    // Div 5, freeze at cnt=2 for 10 cycles, then 3 more edges to CE.
    DIV    = 8'd5;
    DIV_LD = 1'b1;
    tick();
    check_output("e_ld", CE, 1'b0);
    DIV_LD = 1'b0;
    tick();
    check_output("e_c2", CE, 1'b0);
    tick();
    check_output("e_wrap3", CE, 1'b1);
    tick();
    check_output("e_c1", CE, 1'b0);
    tick();
    check_output("e_c2b", CE, 1'b0);
    EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("e_frozen", CE, 1'b0);
    end
    EN = 1'b1;
    tick();
    check_output("e_c3", CE, 1'b0);
    tick();
    check_output("e_c4", CE, 1'b0);
    tick();
    check_output("e_resume", CE, 1'b1);

    // CE is high here; CLR must drop it without an edge.
    pulse_clr("f1");

    // SET_LEN=2 instance, one-cycle request.
    sreq2 = 1'b1;
    tick();
    check_output("g_s1",   s2,    1'b1);
    check_output("g_sack", sack2, 1'b0);
    check_output("g_ce",   ce2,   1'b0);
    sreq2 = 1'b0;
    tick();
    check_output("g_s2", s2, 1'b1);
    tick();
    check_output("g_s_fall",  s2,    1'b0);
    check_output("g_sack_up", sack2, 1'b1);
    tick();
    check_output("g_sack_fall", sack2, 1'b0);
    check_output("g_s_low",     s2,    1'b0);

    // S high on one instance, SACK high on the other, with a pending divisor.
    SREQ  = 1'b1;
    sreq2 = 1'b1;
    tick();
    DIV    = 8'd2;
    DIV_LD = 1'b1;
    tick();
    DIV_LD = 1'b0;
    tick();
    check_output("f2_pre_s",    S,     1'b1);
    check_output("f2_pre_sack", sack2, 1'b1);
    SREQ  = 1'b0;
    sreq2 = 1'b0;
    pulse_clr("f2");

    // Pending divisor 2 was discarded: period is back to 3.
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("f2_ce",  CE,  (i % 3) == 2);
      check_output("f2_ce2", ce2, (i % 3) == 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
